// File: rtl/credit_link_receiver.sv
// Far end of a credit-based pipelined link: buffers arriving words, presents them
// on a ready/valid port and returns one registered credit pulse per drained word.
module credit_link_receiver #(
  parameter  int WORD_WIDTH   = 8,
  parameter  int CREDIT_COUNT = 4,
  localparam int OCC_WIDTH    = $clog2(CREDIT_COUNT + 1)
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  link_valid,
  input  logic [WORD_WIDTH-1:0] link_data,
  output logic                  credit_return,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [WORD_WIDTH-1:0] output_data,
  output logic [OCC_WIDTH-1:0]  occupancy,
  output logic                  overflow
);

  localparam int PTR_W = (CREDIT_COUNT > 1) ? $clog2(CREDIT_COUNT) : 1;
  localparam logic [PTR_W-1:0]     LAST_SLOT = PTR_W'(CREDIT_COUNT - 1);
  localparam logic [OCC_WIDTH-1:0] FULL_OCC  = OCC_WIDTH'(CREDIT_COUNT);

  logic [CREDIT_COUNT-1:0][WORD_WIDTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, wr_acc, xfer;

  assign full         = (occupancy == FULL_OCC);
  assign wr_acc       = link_valid & ~full;
  assign output_valid = (occupancy != '0);
  assign xfer         = output_valid & output_ready;
  assign output_data  = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage is reset so output_data reads zero straight out of reset.
  for (genvar i = 0; i < CREDIT_COUNT; i++) begin : g_slot
    always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n)
        mem[i] <= '0;
      else if (wr_acc && wr_ptr == PTR_W'(i))
        mem[i] <= link_data;
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occupancy     <= '0;
      credit_return <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (xfer)   rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_acc, xfer})
        2'b10:   occupancy <= occupancy + OCC_WIDTH'(1);
        2'b01:   occupancy <= occupancy - OCC_WIDTH'(1);
        default: occupancy <= occupancy;
      endcase
      credit_return <= xfer;
      // Full is judged before this cycle's transfer: that credit is not yet back.
      overflow <= overflow | (link_valid & full);
    end
  end

endmodule

// File: tb/tb_credit_link_receiver.sv
// Bench for credit_link_receiver: table vectors on a 4-entry instance, hand sequences,
// and random traffic on 4- and 3-entry instances checked against a queue model.
module tb_credit_link_receiver;

  logic clock = 1'b0;
  logic clear_n = 1'b0;
  always #5 clock = ~clock;

  logic       lv_a = 0, rdy_a = 0, cr_a, vld_a, ovf_a;
  logic [7:0] ld_a = 0, data_a;
  logic [2:0] occ_a;
  logic       lv_b = 0, rdy_b = 0, cr_b, vld_b, ovf_b;
  logic [7:0] ld_b = 0, data_b;
  logic [1:0] occ_b;

  credit_link_receiver #(.WORD_WIDTH(8), .CREDIT_COUNT(4)) dut_a (
    .clock(clock), .clear_n(clear_n), .link_valid(lv_a), .link_data(ld_a),
    .credit_return(cr_a), .output_valid(vld_a), .output_ready(rdy_a),
    .output_data(data_a), .occupancy(occ_a), .overflow(ovf_a));

  credit_link_receiver #(.WORD_WIDTH(8), .CREDIT_COUNT(3)) dut_b (
    .clock(clock), .clear_n(clear_n), .link_valid(lv_b), .link_data(ld_b),
    .credit_return(cr_b), .output_valid(vld_b), .output_ready(rdy_b),
    .output_data(data_b), .occupancy(occ_b), .overflow(ovf_b));

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of words, a sticky error flag, and a pending-credit flag.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int  cap[2] = '{4, 3};
  bit  m_ovf[2];
  bit  m_cr[2];

  task automatic model_edge(input int d, input bit lv, input logic [7:0] ld, input bit rdy);
    int  sz;
    bit  pop, push;
    sz   = (d == 0) ? q0.size() : q1.size();
    pop  = (sz != 0) && rdy;
    push = lv && (sz < cap[d]);
    if (lv && sz == cap[d]) m_ovf[d] = 1'b1;
    if (pop)  begin if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front()); end
    if (push) begin if (d == 0) q0.push_back(ld); else q1.push_back(ld); end
    m_cr[d] = pop;
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete();
    m_ovf = '{0, 0};
    m_cr  = '{0, 0};
  endtask

  task automatic model_check(input int d);
    int sz;
    logic [7:0] fr;
    sz = (d == 0) ? q0.size() : q1.size();
    fr = (sz == 0) ? 8'h00 : ((d == 0) ? q0[0] : q1[0]);
    chk($sformatf("m%0d_occ", d), (d == 0) ? int'(occ_a) : int'(occ_b), sz);
    chk($sformatf("m%0d_vld", d), (d == 0) ? int'(vld_a) : int'(vld_b), int'(sz != 0));
    if (sz != 0)
      chk($sformatf("m%0d_data", d), (d == 0) ? int'(data_a) : int'(data_b), int'(fr));
    chk($sformatf("m%0d_cr", d), (d == 0) ? int'(cr_a) : int'(cr_b), int'(m_cr[d]));
    chk($sformatf("m%0d_ovf", d), (d == 0) ? int'(ovf_a) : int'(ovf_b), int'(m_ovf[d]));
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge(0, lv_a, ld_a, rdy_a);
    model_edge(1, lv_b, ld_b, rdy_b);
    #1;
    model_check(0);
    model_check(1);
  endtask

  typedef struct {
    bit lv; logic [7:0] ld; bit rdy;
    int occ; bit vld; logic [7:0] data; bit chkd; bit cr; bit ovf;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit lv, logic [7:0] ld, bit rdy, int occ, bit vld,
                              logic [7:0] data, bit chkd, bit cr, bit ovf);
    vec_t v;
    v.lv = lv; v.ld = ld; v.rdy = rdy; v.occ = occ; v.vld = vld;
    v.data = data; v.chkd = chkd; v.cr = cr; v.ovf = ovf;
    return v;
  endfunction

  logic [7:0] got[$];
  bit b_lv[12]  = '{1,1,1,0,1,1,1,1,0,0,0,0};
  bit b_rdy[12] = '{0,0,1,1,0,1,1,0,1,1,1,1};

  initial begin
    // Fill from empty, no draining
    vt.push_back(mk(1, 8'h11, 0, 1, 1, 8'h11, 1, 0, 0));
    vt.push_back(mk(1, 8'h22, 0, 2, 1, 8'h11, 1, 0, 0));
    vt.push_back(mk(1, 8'h33, 0, 3, 1, 8'h11, 1, 0, 0));
    vt.push_back(mk(1, 8'h44, 0, 4, 1, 8'h11, 1, 0, 0));
    // Drain full buffer: one credit per transfer, back to back
    vt.push_back(mk(0, 8'h00, 1, 3, 1, 8'h22, 1, 1, 0));
    vt.push_back(mk(0, 8'h00, 1, 2, 1, 8'h33, 1, 1, 0));
    vt.push_back(mk(0, 8'h00, 1, 1, 1, 8'h44, 1, 1, 0));
    vt.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 0));
    vt.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0));
    // Streaming at occupancy 1, words 0..9
    vt.push_back(mk(1, 8'h00, 0, 1, 1, 8'h00, 1, 0, 0));
    for (int i = 1; i < 10; i++)
      vt.push_back(mk(1, 8'(i), 1, 1, 1, 8'(i), 1, 1, 0));
    vt.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0));
    // Full plus write plus transfer: word dropped, transfer and credit still happen
    vt.push_back(mk(1, 8'h11, 0, 1, 1, 8'h11, 1, 0, 0));
    vt.push_back(mk(1, 8'h22, 0, 2, 1, 8'h11, 1, 0, 0));
    vt.push_back(mk(1, 8'h33, 0, 3, 1, 8'h11, 1, 0, 0));
    vt.push_back(mk(1, 8'h44, 0, 4, 1, 8'h11, 1, 0, 0));
    vt.push_back(mk(1, 8'hEE, 1, 3, 1, 8'h22, 1, 1, 1));
    vt.push_back(mk(0, 8'h00, 0, 3, 1, 8'h22, 1, 0, 1));
    vt.push_back(mk(0, 8'h00, 1, 2, 1, 8'h33, 1, 1, 1));
    vt.push_back(mk(0, 8'h00, 1, 1, 1, 8'h44, 1, 1, 1));
    vt.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 1));
    vt.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1));

    model_reset();
    #2;
    chk("rst_occ", int'(occ_a), 0);
    chk("rst_vld", int'(vld_a), 0);
    chk("rst_data", int'(data_a), 0);
    chk("rst_cr", int'(cr_a), 0);
    chk("rst_ovf", int'(ovf_a), 0);
    chk("rst_occ_b", int'(occ_b), 0);
    #10 clear_n = 1'b1;
    @(posedge clock); #1;

    foreach (vt[i]) begin
      lv_a = vt[i].lv; ld_a = vt[i].ld; rdy_a = vt[i].rdy;
      tick();
      chk($sformatf("v%0d_occ", i), int'(occ_a), vt[i].occ);
      chk($sformatf("v%0d_vld", i), int'(vld_a), int'(vt[i].vld));
      if (vt[i].chkd) chk($sformatf("v%0d_data", i), int'(data_a), int'(vt[i].data));
      chk($sformatf("v%0d_cr", i), int'(cr_a), int'(vt[i].cr));
      chk($sformatf("v%0d_ovf", i), int'(ovf_a), int'(vt[i].ovf));
    end
    lv_a = 0; rdy_a = 0;

    // Wrap on the 3-entry instance with interleaved writes and reads
    begin
      int k = 0;
      for (int c = 0; c < 12; c++) begin
        lv_b = b_lv[c]; rdy_b = b_rdy[c];
        ld_b = 8'hA0 + 8'(k);
        if (b_lv[c]) k++;
        if (vld_b && rdy_b) got.push_back(data_b);
        tick();
      end
      lv_b = 0; rdy_b = 0;
      chk("wrap_count", got.size(), 7);
      foreach (got[i]) chk($sformatf("wrap_word%0d", i), int'(got[i]), 'hA0 + i);
      chk("wrap_ovf", int'(ovf_b), 0);
    end

    // Asynchronous reset with two words buffered and a credit pending
    lv_a = 1; ld_a = 8'h31; tick();
    ld_a = 8'h32; tick();
    ld_a = 8'h33; tick();
    lv_a = 0; rdy_a = 1; tick();
    chk("pre_rst_occ", int'(occ_a), 2);
    chk("pre_rst_cr", int'(cr_a), 1);
    rdy_a = 0;
    #2 clear_n = 1'b0;
    #1;
    chk("arst_occ", int'(occ_a), 0);
    chk("arst_vld", int'(vld_a), 0);
    chk("arst_data", int'(data_a), 0);
    chk("arst_cr", int'(cr_a), 0);
    chk("arst_ovf", int'(ovf_a), 0);
    model_reset();
    #2 clear_n = 1'b1;
    tick();
    chk("post_rst_cr", int'(cr_a), 0);
    lv_a = 1; ld_a = 8'h5A; tick();
    chk("post_rst_occ", int'(occ_a), 1);
    chk("post_rst_data", int'(data_a), 'h5A);
    lv_a = 0; rdy_a = 1; tick();
    chk("post_rst_cr2", int'(cr_a), 1);
    chk("post_rst_empty", int'(vld_a), 0);

    // Random traffic on both instances, biased toward filling up
    for (int c = 0; c < 600; c++) begin
      lv_a  = ($urandom_range(0, 99) < 60);
      ld_a  = 8'($urandom);
      rdy_a = ($urandom_range(0, 99) < 45);
      lv_b  = ($urandom_range(0, 99) < 55);
      ld_b  = 8'($urandom);
      rdy_b = ($urandom_range(0, 99) < 50);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
